// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: load/store encodings and stage enums.
// Pure declarations; no logic, no latency, no flow control.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [31:0] LB  = {{17{1'b?}}, 3'b000, {5{1'b?}}, OPC_LOAD};
    localparam logic [31:0] LH  = {{17{1'b?}}, 3'b001, {5{1'b?}}, OPC_LOAD};
    localparam logic [31:0] LW  = {{17{1'b?}}, 3'b010, {5{1'b?}}, OPC_LOAD};
    localparam logic [31:0] LBU = {{17{1'b?}}, 3'b100, {5{1'b?}}, OPC_LOAD};
    localparam logic [31:0] LHU = {{17{1'b?}}, 3'b101, {5{1'b?}}, OPC_LOAD};
    localparam logic [31:0] SB  = {{17{1'b?}}, 3'b000, {5{1'b?}}, OPC_STORE};
    localparam logic [31:0] SH  = {{17{1'b?}}, 3'b001, {5{1'b?}}, OPC_STORE};
    localparam logic [31:0] SW  = {{17{1'b?}}, 3'b010, {5{1'b?}}, OPC_STORE};

    typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational (zero latency); no flow control.
module lsu_align
    import riscv_pkg::*;
(
    input  mem_size_e   size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    assign wdata   = rs2 << {offset, 3'b000};
    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        be         = 4'b1111;
        load_data  = shifted;
        misaligned = 1'b0;
        case (size)
            BYTE: begin
                be        = 4'b0001 << offset;
                load_data = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            end
            HALF: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                misaligned = offset[0];
                load_data  = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            end
            WORD: begin
                be         = 4'b1111;
                misaligned = |offset;
                load_data  = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores on a req/gnt/rvalid port, passes other ops through.
// Latency 1 cycle (non-mem, misaligned, granted store), 2+ for loads; stalls upstream while an access is open.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [31:0]           instr_i,
    input  logic [31:0]           alu_result_i,
    input  logic [31:0]           rs2_data_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [31:0]           instr_o,
    output logic [31:0]           alu_result_o,
    output logic [31:0]           data_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_e  state;
    logic [CW-1:0] cnt;

    logic        is_load, is_store, is_mem, is_unsigned;
    mem_size_e   size;
    logic        misaligned;
    logic [31:0] load_data;
    logic        timeout_hit;
    logic        complete, abort, in_op;

    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_unsigned = 1'b0;
        size        = WORD;
        casez (instr_i)
            LB:  begin is_load = 1'b1; size = BYTE; end
            LH:  begin is_load = 1'b1; size = HALF; end
            LW:  begin is_load = 1'b1; size = WORD; end
            LBU: begin is_load = 1'b1; size = BYTE; is_unsigned = 1'b1; end
            LHU: begin is_load = 1'b1; size = HALF; is_unsigned = 1'b1; end
            SB:  begin is_store = 1'b1; size = BYTE; end
            SH:  begin is_store = 1'b1; size = HALF; end
            SW:  begin is_store = 1'b1; size = WORD; end
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;

    lsu_align u_align (
        .size        (size),
        .is_unsigned (is_unsigned),
        .offset      (alu_result_i[1:0]),
        .rs2         (rs2_data_i),
        .rdata       (mem_rdata_i),
        .be          (mem_be_o),
        .wdata       (mem_wdata_o),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    // Upstream holds its inputs during the access, so the port is driven straight from them.
    assign mem_addr_o = {alu_result_i[ADDR_WIDTH-1:2], 2'b00};
    assign mem_we_o   = is_store;
    assign mem_req_o  = ((state == IDLE) & valid_i & is_mem & ~misaligned) | (state == REQ);

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        complete = 1'b0;
        abort    = 1'b0;
        in_op    = 1'b1;
        case (state)
            IDLE: begin
                in_op    = valid_i & is_mem & ~misaligned;
                complete = valid_i & (~is_mem | misaligned | (is_store & mem_gnt_i));
            end
            REQ: begin
                complete = is_store & mem_gnt_i;
                abort    = ~mem_gnt_i & timeout_hit;
            end
            WAIT: begin
                complete = mem_rvalid_i;
                abort    = ~mem_rvalid_i & timeout_hit;
            end
            default: in_op = 1'b0;
        endcase
    end

    // Release upstream in the cycle the access finishes so it is not replayed.
    assign stall_o = in_op & ~complete & ~abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            valid_o      <= 1'b0;
            instr_o      <= '0;
            alu_result_o <= '0;
            data_o       <= '0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            valid_o    <= complete | abort;
            misalign_o <= (state == IDLE) & valid_i & is_mem & misaligned;
            bus_err_o  <= abort;
            if (complete | abort) begin
                instr_o      <= instr_i;
                alu_result_o <= alu_result_i;
                data_o       <= (complete && state == WAIT) ? load_data : 32'd0;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (valid_i && is_mem && !misaligned) begin
                        if (!mem_gnt_i)   state <= REQ;
                        else if (is_load) state <= WAIT;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        cnt   <= '0;
                        state <= is_load ? WAIT : IDLE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i || timeout_hit) state <= IDLE;
                    else                             cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

    localparam int AW = 12;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [31:0]   instr_i, alu_result_i, rs2_data_i;
    logic          stall_o, valid_o, misalign_o, bus_err_o;
    logic [31:0]   instr_o, alu_result_o, data_o;
    logic          mem_req_o, mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [31:0]   mem_rdata_i;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i),
        .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .stall_o(stall_o),
        .valid_o(valid_o), .instr_o(instr_o), .alu_result_o(alu_result_o),
        .data_o(data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] data;
        logic        misal;
        logic        berr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend_valid = 1'b0;
    int   issued = 0;
    int   seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid_o === 1'b1) begin
            seen++;
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", {31'b0, valid_o}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("instr_o", instr_o, e.instr);
                chk("alu_result_o", alu_result_o, e.alu);
                chk("data_o", data_o, e.data);
                chk("misalign_o", {31'b0, misalign_o}, {31'b0, e.misal});
                chk("bus_err_o", {31'b0, bus_err_o}, {31'b0, e.berr});
            end
        end
    end

    task automatic drive_cycle(input logic v, input logic [31:0] ins, addr, rs2,
                               input logic g, rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        valid_i      = v;
        instr_i      = ins;
        alu_result_i = addr;
        rs2_data_i   = rs2;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        @(negedge clk);
        chk("valid_o_timing", {31'b0, valid_o}, {31'b0, pend_valid});
    endtask

    function automatic logic [31:0] mk_instr(input int f3, input logic [6:0] opc);
        return ($urandom & ~32'h0000707F) | (32'(f3) << 12) | {25'b0, opc};
    endfunction

    // One instruction as seen from upstream: how long it occupies the stage follows
    // from the grant delay d and the read delay r (cycles after grant).
    task automatic issue(input logic [31:0] ins, addr, rs2, input int d, r, input logic [31:0] rd);
        bit ld = 0, st = 0, uns = 0, mis, al, berr = 0;
        int sz = 4, off, n;
        logic [31:0] be, wd, raw;
        exp_t e;
        if (ins[6:0] == 7'b0000011) begin
            case (ins[14:12])
                3'd0: begin ld = 1; sz = 1; end
                3'd1: begin ld = 1; sz = 2; end
                3'd2: begin ld = 1; sz = 4; end
                3'd4: begin ld = 1; sz = 1; uns = 1; end
                3'd5: begin ld = 1; sz = 2; uns = 1; end
                default: ;
            endcase
        end else if (ins[6:0] == 7'b0100011 && ins[14:12] <= 3'd2) begin
            st = 1;
            sz = 1 << ins[14:12];
        end
        off = int'(addr[1:0]);
        mis = (ld || st) && (off % sz != 0);
        al  = (ld || st) && !mis;
        be  = (sz == 4) ? 32'hF : (((32'd1 << sz) - 1) << off);
        wd  = rs2 << (8 * off);
        raw = rd >> (8 * off);
        if (sz < 4) begin
            raw = raw % (32'd1 << (8 * sz));
            if (!uns && raw >= (32'd1 << (8 * sz - 1))) raw = raw - (32'd1 << (8 * sz));
        end
        if (!al)           n = 1;
        else if (d > TO) begin n = TO + 1; berr = 1; end
        else if (st)       n = d + 1;
        else if (r > TO) begin n = d + 1 + TO; berr = 1; end
        else               n = d + 1 + r;
        e.instr = ins;
        e.alu   = addr;
        e.data  = (ld && al && !berr) ? raw : 32'd0;
        e.misal = mis;
        e.berr  = berr;
        sb_q.push_back(e);
        issued++;
        for (int c = 1; c <= n; c++) begin
            bit g, rv, req;
            g   = al && (c == d + 1);
            rv  = al && ld && (d <= TO) && (c == d + 1 + r);
            req = al && (c <= d + 1) && (c <= TO + 1);
            drive_cycle(1'b1, ins, addr, rs2, g, rv, rv ? rd : $urandom);
            chk("stall_o", {31'b0, stall_o}, {31'b0, (c < n)});
            chk("mem_req_o", {31'b0, mem_req_o}, {31'b0, req});
            if (req) begin
                chk("mem_addr_o", {20'b0, mem_addr_o}, addr & 32'hFFC);
                chk("mem_be_o", {28'b0, mem_be_o}, be);
                chk("mem_we_o", {31'b0, mem_we_o}, {31'b0, st});
                if (st) chk("mem_wdata_o", mem_wdata_o, wd);
            end
            pend_valid = (c == n);
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, $urandom, $urandom, $urandom, 1'b0, 1'b0, $urandom);
        chk("idle_mem_req_o", {31'b0, mem_req_o}, 32'd0);
        chk("idle_stall_o", {31'b0, stall_o}, 32'd0);
        pend_valid = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid_o"}, {31'b0, valid_o}, 32'd0);
        chk({tag, "_instr_o"}, instr_o, 32'd0);
        chk({tag, "_alu_result_o"}, alu_result_o, 32'd0);
        chk({tag, "_data_o"}, data_o, 32'd0);
        chk({tag, "_misalign_o"}, {31'b0, misalign_o}, 32'd0);
        chk({tag, "_bus_err_o"}, {31'b0, bus_err_o}, 32'd0);
        chk({tag, "_mem_req_o"}, {31'b0, mem_req_o}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lw_i;
        rst = 1'b1; valid_i = 1'b0; instr_i = '0; alu_result_i = '0; rs2_data_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases
        issue(mk_instr(2, 7'b0100011), 32'h104, 32'hDEADBEEF, 0, 1, 0);
        issue(mk_instr(0, 7'b0100011), 32'h103, 32'h000000A5, 0, 1, 0);
        issue(mk_instr(0, 7'b0000011), 32'h102, 0, 0, 1, 32'h12F45678);
        issue(mk_instr(4, 7'b0000011), 32'h102, 0, 0, 1, 32'h12F45678);
        issue(mk_instr(1, 7'b0000011), 32'h101, 0, 0, 1, 32'h55555555);
        issue(mk_instr(2, 7'b0000011), 32'h208, 0, 3, 2, 32'h00001234);
        issue(mk_instr(2, 7'b0000011), 32'h30C, 0, 9, 1, 32'h0);
        issue(mk_instr(2, 7'b0000011), 32'h310, 0, 1, 7, 32'h0);
        issue(mk_instr(0, 7'b0110011), 32'hCAFEF00D, 0, 0, 1, 32'h0);
        idle_cycle();

        // Reset while waiting for read data; the late rvalid must be ignored.
        lw_i = mk_instr(2, 7'b0000011);
        drive_cycle(1'b1, lw_i, 32'h200, 0, 1'b1, 1'b0, 0);
        chk("rst_test_stall_req", {31'b0, stall_o}, 32'd1);
        pend_valid = 1'b0;
        drive_cycle(1'b1, lw_i, 32'h200, 0, 1'b0, 1'b0, 0);
        chk("rst_test_stall_wait", {31'b0, stall_o}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1; valid_i = 1'b0; mem_gnt_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
        @(negedge clk);
        check_cleared("midreset");
        idle_cycle();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int k, f3, d, r;
            logic [6:0] opc;
            k = $urandom_range(0, 9);
            if (k <= 4)      begin opc = 7'b0000011; f3 = (k <= 2) ? k : k + 1; end
            else if (k <= 7) begin opc = 7'b0100011; f3 = k - 5; end
            else if (k == 8) begin opc = 7'b0110011; f3 = $urandom_range(0, 7); end
            else             begin opc = 7'b0000011; f3 = ($urandom_range(0, 1) == 0) ? 3 : $urandom_range(6, 7); end
            d = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 6);
            r = $urandom_range(1, 6);
            issue(mk_instr(f3, opc), $urandom, $urandom, d, r, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        chk("pulse_count", seen, issued);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
